// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - memory pipeline stage with a wait-stated, byte-laned data array
module mem_stage_sram #(
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEST_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [1:0]        size_in,
  input  logic              sign_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       load_data_out,
  output logic              addr_err
);

  localparam int         WORDS   = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN   = 33'd4 << DEPTH_LOG2;
  localparam logic       NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] mem [0:WORDS-1];

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic                  access;
  logic                  is_load;
  logic                  range_err;
  logic                  align_err;
  logic                  size_err;
  logic                  err;
  logic                  commit;
  logic                  mem_we;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_fmt;
  logic [31:0]           load_next;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;

  assign off      = alu_result_in - BASE_ADDR;
  assign word_idx = off[DEPTH_LOG2+1:2];
  assign lane     = off[1:0];
  assign access   = mem_r_en_in | mem_w_en_in;
  // a combined read+write request is a store, so it never returns load data
  assign is_load  = mem_r_en_in & ~mem_w_en_in;

  assign range_err = ({1'b0, off} >= SPAN);
  assign align_err = ((size_in == 2'b01) & off[0]) | ((size_in == 2'b10) & (|off[1:0]));
  assign size_err  = (size_in == 2'b11);
  assign err       = access & (range_err | align_err | size_err);

  assign rd_word = mem[word_idx];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_fmt = rd_word;
    case (size_in)
      2'b00:   load_fmt = sign_in ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      2'b01:   load_fmt = sign_in ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: load_fmt = rd_word;
    endcase
    load_next = (is_load & ~err) ? load_fmt : 32'd0;
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = store_data_in;
    case (size_in)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{store_data_in[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = store_data_in;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = store_data_in;
      end
    endcase
  end

  // the edge on which the output register loads and any store lands
  assign commit = ~pause_in &
                  (((state == S_IDLE) & (~access | NO_WAIT)) | (state == S_DONE));
  assign mem_we = commit & mem_w_en_in & ~err & ~rst;
  assign freeze = ((state == S_IDLE) & access & ~NO_WAIT) | (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access & ~NO_WAIT) begin
            cnt   <= WAIT_M1;
            state <= (WAIT_CYCLES == 1) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_DONE;
        end
        S_DONE: begin
          if (~pause_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest_out       <= '0;
      alu_result_out <= 32'd0;
      load_data_out  <= 32'd0;
      addr_err       <= 1'b0;
    end else if (commit) begin
      wb_en_out      <= wb_en_in;
      mem_r_en_out   <= mem_r_en_in;
      dest_out       <= dest_in;
      alu_result_out <= alu_result_in;
      load_data_out  <= load_next;
      addr_err       <= err;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - randomized bench for mem_stage_sram against a byte-addressed memory model
module tb_mem_stage_sram;

  localparam int DL   = 6;
  localparam int BASE = 1024;
  localparam int W    = 2;
  localparam int DW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          pause_in, wb_en_in, mem_r_en_in, mem_w_en_in, sign_in;
  logic [1:0]    size_in;
  logic [DW-1:0] dest_in;
  logic [31:0]   alu_result_in, store_data_in;
  logic          freeze, wb_en_out, mem_r_en_out, addr_err;
  logic [DW-1:0] dest_out;
  logic [31:0]   alu_result_out, load_data_out;

  mem_stage_sram #(
    .DEPTH_LOG2(DL), .BASE_ADDR(32'(BASE)), .WAIT_CYCLES(W), .DEST_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .pause_in(pause_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .size_in(size_in), .sign_in(sign_in), .dest_in(dest_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .dest_out(dest_out), .alu_result_out(alu_result_out),
    .load_data_out(load_data_out), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // byte-addressed view of the array, offset 0 = BASE
  logic [7:0] mb [0:255];

  logic          chk_en = 1'b0;
  logic          e_freeze, e_wb, e_mre, e_err, e_ld_chk;
  logic [DW-1:0] e_dest;
  logic [31:0]   e_alu, e_ld;
  logic          pin_lv = 1'b0, pin_err = 1'b0, pin_nop = 1'b0, pin_zero = 1'b0;
  logic [31:0]   pin_ld = 32'd0;

  int vecs = 0;
  int bad  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("freeze", 32'(freeze), 32'(e_freeze));
      chk("wb_en_out", 32'(wb_en_out), 32'(e_wb));
      chk("mem_r_en_out", 32'(mem_r_en_out), 32'(e_mre));
      chk("dest_out", 32'(dest_out), 32'(e_dest));
      chk("alu_result_out", alu_result_out, e_alu);
      chk("addr_err", 32'(addr_err), 32'(e_err));
      if (e_ld_chk) chk("load_data_out", load_data_out, e_ld);
      if (pin_lv) begin
        chk("lit_load_data", load_data_out, pin_ld);
        chk("lit_addr_err", 32'(addr_err), 32'(pin_err));
      end
      if (pin_nop) begin
        chk("lit_nop_wb", 32'(wb_en_out), 32'd1);
        chk("lit_nop_dest", 32'(dest_out), 32'd5);
        chk("lit_nop_alu", alu_result_out, 32'h1234);
        chk("lit_nop_err", 32'(addr_err), 32'd0);
      end
      if (pin_zero) begin
        chk("lit_rst_outs", {26'd0, freeze, wb_en_out, mem_r_en_out, addr_err, |dest_out,
                             |alu_result_out}, 32'd0);
        chk("lit_rst_load", load_data_out, 32'd0);
      end
    end
  end

  function automatic logic [31:0] m_load(input logic [7:0] o, input logic [1:0] sz, input logic sg);
    logic [7:0] b0, b1;
    b0 = mb[o];
    b1 = mb[o + 8'd1];
    case (sz)
      2'd0:    return sg ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'd1:    return sg ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
      default: return {mb[o + 8'd3], mb[o + 8'd2], b1, b0};
    endcase
  endfunction

  task automatic drive_idle();
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; size_in = 2'b00;
    sign_in = 1'b0; dest_in = '0; alu_result_in = 32'd0; store_data_in = 32'd0; pause_in = 1'b0;
  endtask

  // presents one op and returns just after the edge on which it retires
  task automatic do_op(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                       input logic wb, input logic [DW-1:0] d, input logic [31:0] a,
                       input logic [31:0] sd, input int p);
    logic [31:0] off;
    logic        acc, err;
    off = a - 32'(BASE);
    acc = r | w;
    err = acc && (off >= 32'd256 || sz == 2'b11 || (sz == 2'b01 && off[0]) ||
                  (sz == 2'b10 && off[1:0] != 2'b00));
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w; size_in = sz; sign_in = sg;
    dest_in = d; alu_result_in = a; store_data_in = sd; pause_in = 1'b0;
    e_freeze = acc;
    if (acc) begin
      repeat (W) @(posedge clk);
      #1;
      e_freeze = 1'b0;
    end
    if (p > 0) begin
      pause_in = 1'b1;
      repeat (p) @(posedge clk);
      #1;
      pause_in = 1'b0;
    end
    @(posedge clk);
    #1;
    e_ld = 32'd0;
    if (acc && !err && r && !w) e_ld = m_load(off[7:0], sz, sg);
    if (acc && !err && w) begin
      mb[off[7:0]] = sd[7:0];
      if (sz != 2'b00) mb[off[7:0] + 8'd1] = sd[15:8];
      if (sz == 2'b10) begin
        mb[off[7:0] + 8'd2] = sd[23:16];
        mb[off[7:0] + 8'd3] = sd[31:24];
      end
    end
    e_wb = wb; e_mre = r; e_dest = d; e_alu = a; e_err = err;
    e_ld_chk = (acc && err) || (r && !w);
    drive_idle();
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    e_wb = 1'b0; e_mre = 1'b0; e_dest = '0; e_alu = 32'd0; e_err = 1'b0; e_ld_chk = 1'b0;
    pin_lv = 1'b0; pin_nop = 1'b0; pin_zero = 1'b0;
  endtask

  task automatic load_pin(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] exp, input logic exp_err);
    do_op(1'b1, 1'b0, sz, sg, 1'b1, 5'd3, a, 32'd0, 0);
    pin_lv = 1'b1; pin_ld = exp; pin_err = exp_err;
    idle_cycle();
  endtask

  initial begin
    logic r, w, sg, wb;
    logic [1:0] sz;
    logic [31:0] a;
    int p;

    drive_idle();
    rst = 1'b1;
    e_freeze = 1'b0; e_wb = 1'b0; e_mre = 1'b0; e_dest = '0; e_alu = 32'd0;
    e_err = 1'b0; e_ld = 32'd0; e_ld_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    pin_zero = 1'b1;
    idle_cycle();

    do_op(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd5, 32'h1234, 32'd0, 0);
    pin_nop = 1'b1;
    idle_cycle();

    do_op(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'd1032, 32'hDEADBEEF, 0);
    idle_cycle();
    load_pin(2'b10, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);

    do_op(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'd1033, 32'h0000005A, 0);
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'd1034, 32'h000000F0, 0);
    load_pin(2'b10, 1'b0, 32'd1032, 32'hDEF05AEF, 1'b0);
    load_pin(2'b00, 1'b1, 32'd1034, 32'hFFFFFFF0, 1'b0);
    load_pin(2'b00, 1'b0, 32'd1034, 32'h000000F0, 1'b0);
    load_pin(2'b01, 1'b1, 32'd1032, 32'h00005AEF, 1'b0);

    load_pin(2'b10, 1'b0, 32'd1034, 32'd0, 1'b1);
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'd1280, 32'h99999999, 0);
    pin_lv = 1'b1; pin_ld = 32'd0; pin_err = 1'b1;
    idle_cycle();
    load_pin(2'b10, 1'b0, 32'd1020, 32'd0, 1'b1);
    load_pin(2'b11, 1'b0, 32'd1032, 32'd0, 1'b1);
    load_pin(2'b10, 1'b0, 32'd1032, 32'hDEF05AEF, 1'b0);

    do_op(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'd1040, 32'h11223344, 3);
    idle_cycle();
    load_pin(2'b10, 1'b0, 32'd1040, 32'h11223344, 1'b0);

    // abort a store one cycle into its wait states
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1; size_in = 2'b10;
    alu_result_in = 32'd1032; store_data_in = 32'hCAFEF00D;
    e_freeze = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    e_freeze = 1'b0; e_wb = 1'b0; e_mre = 1'b0; e_dest = '0; e_alu = 32'd0; e_err = 1'b0;
    e_ld = 32'd0; e_ld_chk = 1'b1;
    pin_zero = 1'b1;
    idle_cycle();
    load_pin(2'b10, 1'b0, 32'd1032, 32'hDEF05AEF, 1'b0);

    for (int i = 0; i < 64; i++) begin
      do_op(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'(BASE + 4 * i), $urandom, 0);
    end

    for (int i = 0; i < 400; i++) begin
      r  = 1'($urandom % 2);
      w  = 1'($urandom % 2);
      sz = 2'($urandom % 4);
      sg = 1'($urandom % 2);
      wb = 1'($urandom % 2);
      a  = 32'(BASE - 8) + 32'($urandom_range(0, 271));
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      p  = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(r, w, sz, sg, wb, DW'($urandom % 32), a, $urandom, p);
    end

    idle_cycle();
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
